// File: rtl/register_rename_unit.sv
// register_rename_unit: speculative register alias table with a circular
// free list of physical registers and a per-physical-register ready bit.
// Optional recovery (committed map + flush restore) is built only when the
// macro RENAME_RECOVER_EN is defined; otherwise flush is ignored.
module register_rename_unit #(
    parameter  int LOG_REGS = 32,
    parameter  int PHY_REGS = 64,
    localparam int LW       = $clog2(LOG_REGS),
    localparam int PW       = $clog2(PHY_REGS),
    localparam int FD       = PHY_REGS - LOG_REGS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ren_valid,
    input  logic          ren_uses_rw,
    input  logic [LW-1:0] rs_addr,
    input  logic [LW-1:0] rt_addr,
    input  logic [LW-1:0] rw_addr,
    output logic          ren_stall,
    output logic [PW-1:0] rs_phy,
    output logic [PW-1:0] rt_phy,
    output logic          rs_ready,
    output logic          rt_ready,
    output logic [PW-1:0] rw_phy,
    output logic [PW-1:0] rw_old_phy,
    input  logic          wb_valid,
    input  logic [PW-1:0] wb_phy,
    input  logic          commit_valid,
    input  logic [LW-1:0] commit_log,
    input  logic [PW-1:0] commit_new_phy,
    input  logic [PW-1:0] commit_old_phy,
    input  logic          flush
);

    localparam int FPW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW  = $clog2(FD + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(FD);
    localparam logic [FPW-1:0] PTR_LAST = FPW'(FD - 1);

    logic [PW-1:0]       r_map [LOG_REGS];
    logic [PHY_REGS-1:0] r_ready;
    logic [PW-1:0]       r_fl [FD];
    logic [FPW-1:0]      r_head;
    logic [FPW-1:0]      r_tail;
    logic [CW-1:0]       r_count;

    logic [PW-1:0]  w_alloc;
    logic [PW-1:0]  w_rs_phy;
    logic [PW-1:0]  w_rt_phy;
    logic           w_stall;
    logic           w_fire;
    logic           w_push;
    logic           w_restore;
    logic [FPW-1:0] w_head_inc;
    logic [FPW-1:0] w_tail_inc;
    logic [FPW-1:0] w_tail_next;

`ifdef RENAME_RECOVER_EN
    logic [PW-1:0] r_cmap [LOG_REGS];
    logic [PW-1:0] w_cmap_next [LOG_REGS];

    // Committed map after this cycle's commit; a same-cycle flush restores from this.
    for (genvar gi = 0; gi < LOG_REGS; gi++) begin : g_cmap_next
        assign w_cmap_next[gi] = (commit_valid && (commit_log == LW'(gi)) && (gi != 0))
                                 ? commit_new_phy : r_cmap[gi];
    end

    // Committed (architectural) map, updated in retirement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LOG_REGS; i++) r_cmap[i] <= PW'(i);
        end else begin
            for (int i = 0; i < LOG_REGS; i++) r_cmap[i] <= w_cmap_next[i];
        end
    end

    assign w_restore = flush;
`else
    // Without recovery, flush and the new-mapping half of commit carry no meaning.
    logic w_unused;
    assign w_unused  = ^{flush, commit_log, commit_new_phy};
    assign w_restore = 1'b0;
`endif

    // Allocation, stall and free-list push decisions.
    assign w_alloc = r_fl[r_head];
    assign w_stall = ren_valid && ren_uses_rw && (r_count == '0);
    assign w_fire  = ren_valid && ren_uses_rw && (rw_addr != '0) && !w_stall && !w_restore;
    // A push into a full list is dropped unless a same-cycle fire makes room.
    assign w_push  = commit_valid && (commit_old_phy != '0) && ((r_count != CNT_FULL) || w_fire);

    assign w_head_inc  = (r_head == PTR_LAST) ? '0 : r_head + FPW'(1);
    assign w_tail_inc  = (r_tail == PTR_LAST) ? '0 : r_tail + FPW'(1);
    assign w_tail_next = w_push ? w_tail_inc : r_tail;

    // Source lookups see the map as it stood before this cycle's rename.
    assign w_rs_phy   = (rs_addr == '0) ? '0 : r_map[rs_addr];
    assign w_rt_phy   = (rt_addr == '0) ? '0 : r_map[rt_addr];
    assign rs_phy     = w_rs_phy;
    assign rt_phy     = w_rt_phy;
    assign rs_ready   = (rs_addr == '0) || r_ready[w_rs_phy] || (wb_valid && (wb_phy == w_rs_phy));
    assign rt_ready   = (rt_addr == '0) || r_ready[w_rt_phy] || (wb_valid && (wb_phy == w_rt_phy));
    assign rw_phy     = w_alloc;
    assign rw_old_phy = (rw_addr == '0) ? '0 : r_map[rw_addr];
    assign ren_stall  = w_stall;

    // Free-list pointers and occupancy; a flush rewinds head onto the post-commit tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= CNT_FULL;
        end else begin
            r_tail <= w_tail_next;
            if (w_restore) begin
                r_head  <= w_tail_next;
                r_count <= CNT_FULL;
            end else begin
                if (w_fire) r_head <= w_head_inc;
                case ({w_fire, w_push})
                    2'b10:   r_count <= r_count - CW'(1);
                    2'b01:   r_count <= r_count + CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Free-list storage: retired physical registers are written at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FD; k++) r_fl[k] <= PW'(LOG_REGS + k);
        end else if (w_push) begin
            r_fl[r_tail] <= commit_old_phy;
        end
    end

    // Speculative map: identity at reset, new allocation on fire, committed copy on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LOG_REGS; i++) r_map[i] <= PW'(i);
        end else if (w_restore) begin
`ifdef RENAME_RECOVER_EN
            for (int i = 0; i < LOG_REGS; i++) r_map[i] <= w_cmap_next[i];
`endif
        end else if (w_fire) begin
            r_map[rw_addr] <= w_alloc;
        end
    end

    // Ready bits: writeback sets, allocation clears (clear listed last so it wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= '1;
        end else if (w_restore) begin
            r_ready <= '1;
        end else begin
            if (wb_valid) r_ready[wb_phy] <= 1'b1;
            if (w_fire)   r_ready[w_alloc] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_register_rename_unit.sv
// tb_register_rename_unit: scenario tasks for register_rename_unit with a
// queue scoreboard of expected rename results (default 32/64 configuration).
module tb_register_rename_unit;

    localparam int LW = 5;
    localparam int PW = 6;

    logic          clk;
    logic          rst_n;
    logic          ren_valid;
    logic          ren_uses_rw;
    logic [LW-1:0] rs_addr;
    logic [LW-1:0] rt_addr;
    logic [LW-1:0] rw_addr;
    logic          ren_stall;
    logic [PW-1:0] rs_phy;
    logic [PW-1:0] rt_phy;
    logic          rs_ready;
    logic          rt_ready;
    logic [PW-1:0] rw_phy;
    logic [PW-1:0] rw_old_phy;
    logic          wb_valid;
    logic [PW-1:0] wb_phy;
    logic          commit_valid;
    logic [LW-1:0] commit_log;
    logic [PW-1:0] commit_new_phy;
    logic [PW-1:0] commit_old_phy;
    logic          flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int phy;
        int old;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int log_r;
        int new_p;
        int old_p;
    } pend_t;

    register_rename_unit #(.LOG_REGS(32), .PHY_REGS(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ren_valid      (ren_valid),
        .ren_uses_rw    (ren_uses_rw),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rw_addr        (rw_addr),
        .ren_stall      (ren_stall),
        .rs_phy         (rs_phy),
        .rt_phy         (rt_phy),
        .rs_ready       (rs_ready),
        .rt_ready       (rt_ready),
        .rw_phy         (rw_phy),
        .rw_old_phy     (rw_old_phy),
        .wb_valid       (wb_valid),
        .wb_phy         (wb_phy),
        .commit_valid   (commit_valid),
        .commit_log     (commit_log),
        .commit_new_phy (commit_new_phy),
        .commit_old_phy (commit_old_phy),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ren_valid      = 1'b0;
        ren_uses_rw    = 1'b0;
        rs_addr        = '0;
        rt_addr        = '0;
        rw_addr        = '0;
        wb_valid       = 1'b0;
        wb_phy         = '0;
        commit_valid   = 1'b0;
        commit_log     = '0;
        commit_new_phy = '0;
        commit_old_phy = '0;
        flush          = 1'b0;
    endtask

    // Leaves the bench one time unit after a rising edge with reset released.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n       = 1'b0;
        ren_valid   = 1'b1;
        ren_uses_rw = 1'b1;
        rw_addr     = 5'd3;
        rs_addr     = 5'd7;
        rt_addr     = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        $display("reset: rs=7 rt=9 rw=3 held in reset");
        checks++; if (ren_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d want 0", ren_stall); end
        checks++; if (rw_phy !== 6'd32) begin errors++; $display("FAIL reset_rw_phy got %0d want 32", rw_phy); end
        checks++; if (rs_phy !== 6'd7) begin errors++; $display("FAIL reset_rs_phy got %0d want 7", rs_phy); end
        checks++; if (rt_phy !== 6'd9) begin errors++; $display("FAIL reset_rt_phy got %0d want 9", rt_phy); end
        checks++; if (rs_ready !== 1'b1 || rt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d%0d want 11", rs_ready, rt_ready); end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_rename_basic();
        exp_t e;
        ren_valid = 1'b1; ren_uses_rw = 1'b1; rw_addr = 5'd5; rs_addr = 5'd5;
        sb.push_back('{phy: 32, old: 5});
        #1;
        e = sb.pop_front();
        $display("rename rw=5 -> phy %0d old %0d", rw_phy, rw_old_phy);
        checks++; if (rw_phy !== PW'(e.phy)) begin errors++; $display("FAIL basic_rw_phy got %0d want %0d", rw_phy, e.phy); end
        checks++; if (rw_old_phy !== PW'(e.old)) begin errors++; $display("FAIL basic_rw_old got %0d want %0d", rw_old_phy, e.old); end
        checks++; if (rs_phy !== 6'd5 || rs_ready !== 1'b1) begin errors++; $display("FAIL basic_pre_update_rs got %0d/%0d want 5/1", rs_phy, rs_ready); end
        next_cycle();
        idle_inputs();
        rs_addr = 5'd5;
        #1;
        $display("lookup rs=5 -> phy %0d ready %0d", rs_phy, rs_ready);
        checks++; if (rs_phy !== 6'd32) begin errors++; $display("FAIL basic_rs_phy got %0d want 32", rs_phy); end
        checks++; if (rs_ready !== 1'b0) begin errors++; $display("FAIL basic_rs_ready got %0d want 0", rs_ready); end
    endtask

    task automatic test_wb_bypass();
        wb_valid = 1'b1; wb_phy = 6'd32; rs_addr = 5'd5;
        #1;
        $display("writeback phy 32 with rs=5 -> ready %0d", rs_ready);
        checks++; if (rs_ready !== 1'b1) begin errors++; $display("FAIL wb_bypass got %0d want 1", rs_ready); end
        next_cycle();
        wb_valid = 1'b0;
        #1;
        checks++; if (rs_ready !== 1'b1) begin errors++; $display("FAIL wb_sticky got %0d want 1", rs_ready); end
        idle_inputs();
    endtask

    task automatic test_r0();
        do_reset();
        ren_valid = 1'b1; ren_uses_rw = 1'b1; rw_addr = '0; rs_addr = '0;
        #1;
        $display("rename rw=0 -> old %0d rs0 phy %0d ready %0d", rw_old_phy, rs_phy, rs_ready);
        checks++; if (rw_old_phy !== 6'd0) begin errors++; $display("FAIL r0_old got %0d want 0", rw_old_phy); end
        checks++; if (rs_phy !== 6'd0 || rs_ready !== 1'b1) begin errors++; $display("FAIL r0_rs got %0d/%0d want 0/1", rs_phy, rs_ready); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (rw_phy !== 6'd32) begin errors++; $display("FAIL r0_no_alloc got %0d want 32", rw_phy); end
    endtask

    // Runs from the state left by test_r0 (full free list).
    task automatic test_stall();
        exp_t e;
        int   rw;
        for (int i = 0; i < 32; i++) begin
            rw = (i % 31) + 1;
            ren_valid = 1'b1; ren_uses_rw = 1'b1; rw_addr = LW'(rw);
            sb.push_back('{phy: 32 + i, old: (i < 31) ? rw : 32});
            #1;
            e = sb.pop_front();
            $display("rename rw=%0d -> phy %0d old %0d stall %0d", rw, rw_phy, rw_old_phy, ren_stall);
            checks++; if (rw_phy !== PW'(e.phy) || rw_old_phy !== PW'(e.old)) begin
                errors++; $display("FAIL stall_fill_%0d got %0d/%0d want %0d/%0d", i, rw_phy, rw_old_phy, e.phy, e.old);
            end
            checks++; if (ren_stall !== 1'b0) begin errors++; $display("FAIL stall_early_%0d got 1 want 0", i); end
            next_cycle();
        end
        rw_addr = 5'd1;
        commit_valid = 1'b1; commit_log = 5'd7; commit_new_phy = 6'd38; commit_old_phy = 6'd7;
        #1;
        $display("rename rw=1 with list empty, commit old 7 -> stall %0d", ren_stall);
        checks++; if (ren_stall !== 1'b1) begin errors++; $display("FAIL stall_empty got %0d want 1", ren_stall); end
        next_cycle();
        commit_valid = 1'b0;
        #1;
        $display("retry rename rw=1 -> stall %0d phy %0d", ren_stall, rw_phy);
        checks++; if (ren_stall !== 1'b0) begin errors++; $display("FAIL stall_release got %0d want 0", ren_stall); end
        checks++; if (rw_phy !== 6'd7) begin errors++; $display("FAIL stall_recycled got %0d want 7", rw_phy); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_fire_wb_conflict();
        do_reset();
        ren_valid = 1'b1; ren_uses_rw = 1'b1; rw_addr = 5'd2;
        wb_valid = 1'b1; wb_phy = 6'd32;
        next_cycle();
        idle_inputs();
        rs_addr = 5'd2;
        #1;
        $display("rename rw=2 with wb phy 32 same cycle -> rs phy %0d ready %0d", rs_phy, rs_ready);
        checks++; if (rs_phy !== 6'd32 || rs_ready !== 1'b0) begin errors++; $display("FAIL fire_wb got %0d/%0d want 32/0", rs_phy, rs_ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        commit_valid = 1'b1; commit_old_phy = 6'd9; commit_log = 5'd9;
        next_cycle();
        idle_inputs();
        #1;
        $display("commit into full list -> head phy %0d", rw_phy);
        checks++; if (rw_phy !== 6'd32) begin errors++; $display("FAIL overflow_head got %0d want 32", rw_phy); end
    endtask

    task automatic test_wrap();
        int    fl_q[$];
        int    map_m[32];
        pend_t pend[$];
        pend_t p;
        exp_t  e;
        int    rw;
        int    ph;
        logic  did_commit;
        int    committed_old;
        do_reset();
        for (int k = 0; k < 32; k++) fl_q.push_back(32 + k);
        for (int k = 0; k < 32; k++) map_m[k] = k;
        for (int i = 0; i <= 40; i++) begin
            rw = (i % 31) + 1;
            ph = fl_q.pop_front();
            sb.push_back('{phy: ph, old: map_m[rw]});
            pend.push_back('{log_r: rw, new_p: ph, old_p: map_m[rw]});
            map_m[rw] = ph;
            ren_valid = 1'b1; ren_uses_rw = 1'b1; rw_addr = LW'(rw);
            did_commit = 1'b0;
            committed_old = 0;
            if (i > 0) begin
                p = pend.pop_front();
                commit_valid = 1'b1; commit_log = LW'(p.log_r);
                commit_new_phy = PW'(p.new_p); commit_old_phy = PW'(p.old_p);
                did_commit = 1'b1;
                committed_old = p.old_p;
            end else begin
                commit_valid = 1'b0;
            end
            #1;
            e = sb.pop_front();
            $display("wrap %0d: rename rw=%0d -> phy %0d old %0d commit %0d", i, rw, rw_phy, rw_old_phy, committed_old);
            checks++; if (rw_phy !== PW'(e.phy) || rw_old_phy !== PW'(e.old) || ren_stall !== 1'b0) begin
                errors++; $display("FAIL wrap_%0d got %0d/%0d/%0d want %0d/%0d/0", i, rw_phy, rw_old_phy, ren_stall, e.phy, e.old);
            end
            next_cycle();
            if (did_commit) fl_q.push_back(committed_old);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        rs_addr = 5'd1;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle -> rw_phy %0d rs1 phy %0d", rw_phy, rs_phy);
        checks++; if (rw_phy !== 6'd32) begin errors++; $display("FAIL async_rw_phy got %0d want 32", rw_phy); end
        checks++; if (rs_phy !== 6'd1 || rs_ready !== 1'b1) begin errors++; $display("FAIL async_rs got %0d/%0d want 1/1", rs_phy, rs_ready); end
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
    endtask

`ifdef RENAME_RECOVER_EN
    task automatic test_flush();
        do_reset();
        ren_valid = 1'b1; ren_uses_rw = 1'b1; rw_addr = 5'd3;
        next_cycle();
        rw_addr = 5'd4;
        next_cycle();
        rw_addr = 5'd5;
        commit_valid = 1'b1; commit_log = 5'd3; commit_new_phy = 6'd32; commit_old_phy = 6'd3;
        flush = 1'b1;
        next_cycle();
        idle_inputs();
        rs_addr = 5'd3; rt_addr = 5'd4;
        #1;
        $display("flush after commit r3 -> r3 %0d r4 %0d next %0d", rs_phy, rt_phy, rw_phy);
        checks++; if (rs_phy !== 6'd32) begin errors++; $display("FAIL flush_r3 got %0d want 32", rs_phy); end
        checks++; if (rt_phy !== 6'd4 || rt_ready !== 1'b1) begin errors++; $display("FAIL flush_r4 got %0d/%0d want 4/1", rt_phy, rt_ready); end
        checks++; if (rw_phy !== 6'd33) begin errors++; $display("FAIL flush_head got %0d want 33", rw_phy); end
        checks++; if (rs_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0d want 1", rs_ready); end
    endtask
`else
    task automatic test_flush();
        do_reset();
        ren_valid = 1'b1; ren_uses_rw = 1'b1; rw_addr = 5'd3;
        next_cycle();
        rw_addr = 5'd4;
        flush = 1'b1;
        next_cycle();
        idle_inputs();
        rs_addr = 5'd3; rt_addr = 5'd4;
        #1;
        $display("flush ignored -> r3 %0d r4 %0d next %0d", rs_phy, rt_phy, rw_phy);
        checks++; if (rs_phy !== 6'd32 || rt_phy !== 6'd33) begin errors++; $display("FAIL flush_ignored_map got %0d/%0d want 32/33", rs_phy, rt_phy); end
        checks++; if (rw_phy !== 6'd34) begin errors++; $display("FAIL flush_ignored_head got %0d want 34", rw_phy); end
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_rename_basic();
        test_wb_bypass();
        test_r0();
        test_stall();
        test_fire_wb_conflict();
        test_overflow();
        test_wrap();
        test_async_reset();
        test_flush();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_rename_unit.md
REGISTER_RENAME_UNIT -- requirements
Module: register_rename_unit

Interface
REQ-001 Parameter LOG_REGS, default 32, number of logical registers.
REQ-002 Parameter PHY_REGS, default 64, number of physical registers; PHY_REGS > LOG_REGS.
REQ-003 Derived widths: LW = $clog2(LOG_REGS), PW = $clog2(PHY_REGS), free-list depth FD = PHY_REGS-LOG_REGS.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ren_valid  in  1  decoded instruction presented for rename.
REQ-007 ren_uses_rw  in  1  instruction writes a destination.
REQ-008 rs_addr, rt_addr, rw_addr  in  LW each  logical source/destination indices.
REQ-009 ren_stall  out  1  rename cannot accept this cycle.
REQ-010 rs_phy, rt_phy  out  PW each  physical source mappings.
REQ-011 rs_ready, rt_ready  out  1 each  source value available.
REQ-012 rw_phy  out  PW  newly allocated destination; rw_old_phy  out  PW  prior mapping of rw_addr.
REQ-013 wb_valid  in  1, wb_phy  in  PW  writeback marks physical register ready.
REQ-014 commit_valid  in  1, commit_log  in  LW, commit_new_phy  in  PW, commit_old_phy  in  PW  in-order retirement.
REQ-015 flush  in  1  discard all uncommitted renames.

Function
REQ-016 Rename fires when ren_valid && ren_uses_rw && rw_addr!=0 && !ren_stall; logical register 0 is never renamed and always reads phy 0, ready.
REQ-017 rs_phy/rt_phy/rw_old_phy read the speculative map combinationally, before the same-cycle update.
REQ-018 rw_phy = free-list head entry, combinational; on fire, map[rw_addr] <= rw_phy, ready[rw_phy] <= 0, head advances, count decrements.
REQ-019 ren_stall = ren_valid && ren_uses_rw && count==0; an entry freed by a same-cycle commit is not usable until the next cycle.
REQ-020 Free list: circular array of FD PW-bit entries; head/tail pointers wrap from FD-1 to 0; count 0..FD.
REQ-021 commit_valid writes commit_old_phy at tail, tail advances, count increments; commit_old_phy==0 is not pushed.
REQ-022 Simultaneous fire and commit: count unchanged, both pointers advance.
REQ-023 rs_ready = ready[rs_phy] || (wb_valid && wb_phy==rs_phy); same for rt; wb sets ready[wb_phy] <= 1 next edge.
REQ-024 Same-cycle fire and wb to the same phy: ready cleared wins.
REQ-025 Free-list overflow (commit when count==FD) is illegal; the block holds count at FD and drops the push.

Reset
REQ-026 rst_n low: map[i]=i, ready all 1, free-list entry k = LOG_REGS+k, head=tail=0, count=FD, committed map[i]=i.
REQ-027 Outputs during reset: ren_stall=0, rw_phy=LOG_REGS, rs_phy=rs_addr, rt_phy=rt_addr, readies 1.
REQ-028 Reset asserted mid-operation discards all pending renames immediately, without waiting for a clock.

Configuration
REQ-029 Macro RENAME_RECOVER_EN defined: committed map maintained (cmap[commit_log] <= commit_new_phy on commit); flush copies cmap to speculative map, sets head <= tail (post-commit), count <= FD, ready all 1; fire is suppressed in the flush cycle.
REQ-030 Commit and flush in the same cycle: commit is applied first, then the flush restore.
REQ-031 Macro undefined: no committed map, flush ignored, no recovery logic synthesised.

Verification
REQ-032 Reset, rename rw=5: rw_phy=32, rw_old_phy=5; next cycle rs_addr=5 gives rs_phy=32, rs_ready=0.
REQ-033 32 consecutive renames without commit: 33rd cycle ren_stall=1; one commit of old_phy=7 gives rw_phy=7 on the following cycle.
REQ-034 wb_valid, wb_phy=32 while rs maps to 32: rs_ready=1 in the same cycle, stays 1 afterwards.
REQ-035 Rename rw=0 with ren_uses_rw=1: no allocation, count stays 32, rs_addr=0 gives phy 0, ready.
REQ-036 With RENAME_RECOVER_EN: rename r3->32, r4->33, commit r3 (old 3), flush: r3 maps to 32, r4 maps to 4, count=32, next rw_phy=33.
REQ-037 Head and tail wrap: 40 fire+commit pairs issued back to back; count stays constant and pointers wrap without error.
